mult_div_unit: RTL and testbench

Multi-cycle, parametrised multiply/divide unit holding the architectural HI/LO registers for the MIPS datapath. It replaces the single-cycle combinational MULTIPLY/DIVIDE paths in the ALU. It adds signed and unsigned modes, divide-by-zero flagging, and direct HI/LO writes (MTHI/MTLO). The control unit issues an operation with `start` and stalls on `busy` until `done` pulses.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: opcode and FSM state encodings.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply,
// restoring divide, one bit per cycle, sign correction applied in the FIX state.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               zero_div;

    // Start-time operand conditioning
    logic             signed_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sa        = signed_op & a[WIDTH-1];
        sb        = signed_op & b[WIDTH-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
    end

    // One multiply step: conditionally add the multiplicand into the upper half, shift right.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_next;
    // One restoring-divide step: shift in the next dividend bit, trial-subtract the divisor.
    logic [WIDTH+1:0]   diff;
    logic               qbit;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {sum, acc[WIDTH-1:1]};
        diff     = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, opnd};
        qbit     = ~diff[WIDTH+1];
        div_next = {qbit ? diff[WIDTH-1:0] : {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]},
                    acc[WIDTH-2:0], qbit};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div      <= op[1];
                        neg_res     <= sa ^ sb;
                        neg_rem     <= sa;
                        zero_div    <= op[1] && (b == '0);
                        a_raw       <= a;
                        opnd        <= op[1] ? mag_b : mag_a;
                        acc         <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        state       <= S_CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (zero_div) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results, a monitor
// pops and compares them on every done pulse and checks HI/LO hold while busy.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    mdu_op_t      op = OP_MULT;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           start_cyc;
    } exp_t;

    exp_t         q[$];
    int           checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
    logic [W-1:0] mhi = '0, mlo = '0;
    logic         last_dbz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Reference: architectural MIPS HI/LO results from plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        longint      sx, sy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dbz = 1'b0;
        r.start_cyc = 0;
        case (o)
            2'd0: begin p = sx * sy; {r.hi, r.lo} = p; end
            2'd1: begin up = {32'b0, x} * {32'b0, y}; {r.hi, r.lo} = up; end
            default: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    r.lo = W'(sx / sy);
                    r.hi = W'(sx % sy);
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return W'($urandom_range(0, 20));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin @(negedge clk); g++; end
        if (busy) bound_fail("idle_wait");
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic wr = 1'b0);
        exp_t e;
        wait_idle();
        chk("dbz_sticky", dbz, last_dbz);
        e = model(o, x, y);
        e.start_cyc = cyc + 1;
        q.push_back(e);
        op = mdu_op_t'(o); a = x; b = y; start = 1'b1;
        hi_we = wr; lo_we = wr; wdata = ~x;
        @(posedge clk); #1;
        chk("busy_after_start", busy, 1'b1);
        chk("dbz_cleared_by_start", dbz, 1'b0);
        last_dbz = e.dbz;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = W'($urandom); b = W'($urandom); op = mdu_op_t'($urandom_range(0, 3));
    endtask

    // Drive start and HI/LO writes during CALC; all must be ignored.
    task automatic harass();
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
            wdata = W'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic mtx(input logic h, input logic l, input logic [W-1:0] d);
        wait_idle();
        hi_we = h; lo_we = l; wdata = d;
        @(posedge clk); #1;
        if (h) mhi = d;
        if (l) mlo = d;
        chk("mt_hi", hi, mhi);
        chk("mt_lo", lo, mlo);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                busy_cnt = 0;
            end else if (done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("res_hi", hi, e.hi);
                    chk("res_lo", lo, e.lo);
                    chk("res_dbz", dbz, e.dbz);
                    chk("latency", 64'(cyc - e.start_cyc), 64'(W + 1));
                    chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));
                    chk("busy_low_on_done", busy, 1'b0);
                    mhi = e.hi; mlo = e.lo;
                end
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
                chk("hold_hi", hi, mhi);
                chk("hold_lo", lo, mlo);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", dbz, 1'b0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        @(negedge clk); reset = 1'b0;

        issue(2'd1, 32'd10, 32'd2);
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd2, -32'd7, 32'd2);
        issue(2'd3, 32'd10, 32'd2);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd3, 32'd5, 32'd0);
        issue(2'd2, -32'd5, 32'd0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        issue(2'd3, 32'd100, 32'd7);
        harass();
        mtx(1'b1, 1'b1, 32'h1234);
        mtx(1'b1, 1'b0, 32'hCAFE_0001);
        mtx(1'b0, 1'b1, 32'hBEEF_0002);
        issue(2'd1, 32'd3, 32'd4, 1'b1);

        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), rnd_val(),
                  ($urandom_range(0, 7) == 0) ? '0 : rnd_val());

        // Reset in the middle of CALC
        issue(2'd0, 32'h0001_2345, 32'hFFFF_FF00);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_hi", hi, '0);
        chk("midreset_lo", lo, '0);
        chk("midreset_dbz", dbz, 1'b0);
        q.delete();
        mhi = '0; mlo = '0; last_dbz = 1'b0;
        @(negedge clk); reset = 1'b0;
        n = 0;
        repeat (W + 6) begin @(negedge clk); if (done) n++; end
        chk("no_done_after_reset", 64'(n), 64'd0);

        issue(2'd3, 32'd1000, 32'd33);
        issue(2'd2, 32'h7FFF_FFFF, -32'd3);

        g = 0;
        while (q.size() > 0 && g < 200) begin @(negedge clk); g++; end
        if (q.size() > 0) bound_fail("drain");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
